// File: rtl/rom_dl_seq.sv
// rom_dl_seq: buffers ioctl download bytes through a 2-entry FIFO into the core ROM port,
// decodes ROM regions, checks download length and sequences core reset.
module rom_dl_seq #(
    parameter logic [15:0] EXP_BYTES     = 16'h6200,
    parameter int          HOLD_CYCLES   = 64,
    parameter logic [63:0] REGION_LIMITS = {16'h4000, 16'h5000, 16'h6000, 16'h6200}
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ioctl_download,
    input  logic        ioctl_wr,
    input  logic [24:0] ioctl_addr,
    input  logic [7:0]  ioctl_dout,
    input  logic        pop_stall,
    output logic        ioctl_wait,
    output logic        dn_wr,
    output logic [15:0] dn_addr,
    output logic [7:0]  dn_data,
    output logic [1:0]  dn_sel,
    output logic        core_reset,
    output logic        dl_done,
    output logic        dl_error,
    output logic [15:0] byte_count
);
    typedef enum logic [2:0] {IDLE, LOAD, DRAIN, HOLD, RUN} state_t;
    state_t      state_q, state_d;
    logic        dl_prev_q;
    logic [24:0] mem_q [2];
    logic        wr_q, rd_q;
    logic [1:0]  cnt_q;
    logic        dn_wr_q;
    logic [15:0] dn_addr_q;
    logic [7:0]  dn_data_q;
    logic [1:0]  dn_sel_q;
    logic        dl_done_q, done_d;
    logic        dl_error_q, err_d;
    logic [15:0] byte_count_q, bc_d, bc_base;
    logic [15:0] hold_q, hold_d;
    logic        dl_rise, push_try, push, drop, pop, head_ok, wr_ok;
    logic [24:0] head;
    logic [1:0]  sel;
    assign dl_rise  = ioctl_download & ~dl_prev_q;
    // pushes are accepted only inside a download this block has seen start
    assign push_try = ioctl_wr & ioctl_download & (state_q == LOAD | dl_rise);
    assign push     = push_try & (cnt_q != 2'd2);
    assign drop     = push_try & ~push;
    assign pop      = (cnt_q != 2'd0) & ~pop_stall & (state_q == LOAD | state_q == DRAIN);
    assign head     = mem_q[rd_q];
    assign head_ok  = ~head[24] & (head[23:8] < REGION_LIMITS[15:0]);
    assign wr_ok    = pop & head_ok;
    assign sel      = head[23:8] < REGION_LIMITS[63:48] ? 2'd0 :
                      head[23:8] < REGION_LIMITS[47:32] ? 2'd1 :
                      head[23:8] < REGION_LIMITS[31:16] ? 2'd2 : 2'd3;
    assign ioctl_wait = (cnt_q == 2'd2) | ((cnt_q == 2'd1) & push);
    assign dn_wr      = dn_wr_q;
    assign dn_addr    = dn_addr_q;
    assign dn_data    = dn_data_q;
    assign dn_sel     = dn_sel_q;
    assign core_reset = state_q != RUN;
    assign dl_done    = dl_done_q;
    assign dl_error   = dl_error_q;
    assign byte_count = byte_count_q;
    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        done_d  = dl_done_q;
        err_d   = (dl_rise ? 1'b0 : dl_error_q) | drop | (pop & ~head_ok);
        bc_base = dl_rise ? 16'h0000 : byte_count_q;
        bc_d    = bc_base + 16'(wr_ok & (bc_base != 16'hFFFF));
        if (dl_rise) begin
            state_d = LOAD;
            hold_d  = '0;
            done_d  = 1'b0;
        end else begin
            unique case (state_q)
                LOAD:  if (!ioctl_download) state_d = DRAIN;
                DRAIN: if (cnt_q == 2'd0) begin
                    state_d = HOLD;
                    hold_d  = '0;
                    if (byte_count_q != EXP_BYTES) err_d = 1'b1;
                end
                // an errored download parks at the end of HOLD until the next download
                HOLD:  if (hold_q != 16'(HOLD_CYCLES - 1)) hold_d = hold_q + 16'd1;
                       else if (!dl_error_q) begin
                           state_d = RUN;
                           done_d  = 1'b1;
                       end
                default: ;
            endcase
        end
    end
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_q] <= {|ioctl_addr[24:16], ioctl_addr[15:0], ioctl_dout};
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            dl_prev_q    <= 1'b1;
            wr_q         <= 1'b0;
            rd_q         <= 1'b0;
            cnt_q        <= 2'd0;
            dn_wr_q      <= 1'b0;
            dn_addr_q    <= '0;
            dn_data_q    <= '0;
            dn_sel_q     <= '0;
            dl_done_q    <= 1'b0;
            dl_error_q   <= 1'b0;
            byte_count_q <= '0;
            hold_q       <= '0;
        end else begin
            state_q      <= state_d;
            dl_prev_q    <= ioctl_download;
            wr_q         <= wr_q ^ push;
            rd_q         <= rd_q ^ pop;
            cnt_q        <= cnt_q + 2'(push) - 2'(pop);
            dn_wr_q      <= wr_ok;
            dl_done_q    <= done_d;
            dl_error_q   <= err_d;
            byte_count_q <= bc_d;
            hold_q       <= hold_d;
            if (wr_ok) begin
                dn_addr_q <= head[23:8];
                dn_data_q <= head[7:0];
                dn_sel_q  <= sel;
            end
        end
    end
endmodule

// File: tb/tb_rom_dl_seq.sv
// tb_rom_dl_seq: directed scenario tests for rom_dl_seq with hand-computed expectations.
module tb_rom_dl_seq;
    logic        clk = 1'b0;
    logic        reset, ioctl_download, ioctl_wr, pop_stall;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_dout;
    logic        ioctl_wait, dn_wr, core_reset, dl_done, dl_error;
    logic [15:0] dn_addr, byte_count;
    logic [7:0]  dn_data;
    logic [1:0]  dn_sel;
    int checks = 0, failures = 0;
    int cyc = 0, wr_cnt, mon_bad, cr_low, last_wr_cyc, cr_fall_cyc;
    logic [15:0] next_exp;
    logic [6:0][1:0] sel_b;
    localparam logic [44:0] RST_VEC = {1'b0, 1'b0, 16'h0, 8'h0, 2'h0, 1'b1, 1'b0, 1'b0, 16'h0};
    rom_dl_seq dut (
        .clk(clk), .reset(reset), .ioctl_download(ioctl_download), .ioctl_wr(ioctl_wr),
        .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout), .pop_stall(pop_stall),
        .ioctl_wait(ioctl_wait), .dn_wr(dn_wr), .dn_addr(dn_addr), .dn_data(dn_data),
        .dn_sel(dn_sel), .core_reset(core_reset), .dl_done(dl_done), .dl_error(dl_error),
        .byte_count(byte_count)
    );
    always #5 clk = ~clk;
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        if (dn_wr) begin
            wr_cnt++;
            last_wr_cyc = cyc;
            if (dn_addr !== next_exp || dn_data !== (dn_addr[7:0] ^ 8'h5A)) mon_bad++;
            next_exp = dn_addr + 16'd1;
            case (dn_addr)
                16'h3FFF: sel_b[6] = dn_sel;
                16'h4000: sel_b[5] = dn_sel;
                16'h4FFF: sel_b[4] = dn_sel;
                16'h5000: sel_b[3] = dn_sel;
                16'h5FFF: sel_b[2] = dn_sel;
                16'h6000: sel_b[1] = dn_sel;
                16'h61FF: sel_b[0] = dn_sel;
                default: ;
            endcase
        end
        if (core_reset === 1'b0) begin
            cr_low++;
            if (cr_fall_cyc < 0) cr_fall_cyc = cyc;
        end
    endtask
    task automatic clr_mon();
        wr_cnt = 0; mon_bad = 0; next_exp = 16'h0; cr_low = 0; cr_fall_cyc = -1; last_wr_cyc = 0;
        sel_b = 'x;
    endtask
    task automatic send(input logic [24:0] a);
        ioctl_wr = 1'b1; ioctl_addr = a; ioctl_dout = a[7:0] ^ 8'h5A;
        step();
        ioctl_wr = 1'b0;
    endtask
    task automatic restart();
        ioctl_download = 1'b0;
        repeat (3) step();
        clr_mon();
        ioctl_download = 1'b1;
        repeat (2) step();
    endtask
    task automatic test_reset();
        #3;
        checks++; if ({ioctl_wait, dn_wr, dn_addr, dn_data, dn_sel, core_reset, dl_done, dl_error, byte_count} !== RST_VEC) begin failures++; $display("FAIL reset_vec got=%h exp=%h", {ioctl_wait, dn_wr, dn_addr, dn_data, dn_sel, core_reset, dl_done, dl_error, byte_count}, RST_VEC); end
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        repeat (2) step();
    endtask
    task automatic test_latency();
        clr_mon();
        ioctl_download = 1'b1;
        repeat (2) step();
        ioctl_wr = 1'b1; ioctl_addr = 25'h4123; ioctl_dout = 8'h23 ^ 8'h5A;
        #1;
        checks++; if (ioctl_wait !== 1'b0) begin failures++; $display("FAIL lat_wait got=%b exp=0", ioctl_wait); end
        step();
        ioctl_wr = 1'b0;
        checks++; if (dn_wr !== 1'b0) begin failures++; $display("FAIL lat_early got=%b exp=0", dn_wr); end
        step();
        checks++; if ({dn_wr, dn_addr, dn_data, dn_sel} !== {1'b1, 16'h4123, 8'h79, 2'd1}) begin failures++; $display("FAIL lat_dn got=%h exp=%h", {dn_wr, dn_addr, dn_data, dn_sel}, {1'b1, 16'h4123, 8'h79, 2'd1}); end
        step();
        checks++; if ({dn_wr, byte_count} !== {1'b0, 16'd1}) begin failures++; $display("FAIL lat_after got=%h exp=%h", {dn_wr, byte_count}, {1'b0, 16'd1}); end
        ioctl_download = 1'b0;
        repeat (4) step();
    endtask
    task automatic test_short_load();
        clr_mon();
        ioctl_download = 1'b1;
        repeat (2) step();
        for (int i = 0; i < 'h6000; i++) send(25'(i));
        ioctl_download = 1'b0;
        repeat (80) step();
        checks++; if ({dl_error, dl_done} !== 2'b10) begin failures++; $display("FAIL short_flags got=%b exp=10", {dl_error, dl_done}); end
        checks++; if (byte_count !== 16'h6000) begin failures++; $display("FAIL short_bc got=%h exp=6000", byte_count); end
        checks++; if (wr_cnt !== 'h6000 || mon_bad !== 0) begin failures++; $display("FAIL short_stream got=%0d/%0d exp=%0d/0", wr_cnt, mon_bad, 'h6000); end
        repeat (60) step();
        checks++; if (cr_low !== 0 || core_reset !== 1'b1) begin failures++; $display("FAIL short_core_reset got=%0d/%b exp=0/1", cr_low, core_reset); end
    endtask
    task automatic test_full_load();
        clr_mon();
        ioctl_download = 1'b1;
        step();
        checks++; if ({dl_error, dl_done, byte_count} !== 18'h0) begin failures++; $display("FAIL full_clear got=%h exp=0", {dl_error, dl_done, byte_count}); end
        step();
        for (int i = 0; i < 'h6200; i++) send(25'(i));
        ioctl_download = 1'b0;
        repeat (90) step();
        checks++; if (wr_cnt !== 'h6200 || mon_bad !== 0) begin failures++; $display("FAIL full_stream got=%0d/%0d exp=%0d/0", wr_cnt, mon_bad, 'h6200); end
        checks++; if (sel_b !== {2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3, 2'd3}) begin failures++; $display("FAIL full_sel got=%b exp=00010110101111", sel_b); end
        checks++; if (byte_count !== 16'h6200) begin failures++; $display("FAIL full_bc got=%h exp=6200", byte_count); end
        // one cycle to see the FIFO empty, then 64 HOLD cycles
        checks++; if (cr_fall_cyc - last_wr_cyc !== 65) begin failures++; $display("FAIL full_hold got=%0d exp=65", cr_fall_cyc - last_wr_cyc); end
        checks++; if ({dl_done, dl_error, core_reset} !== 3'b100) begin failures++; $display("FAIL full_end got=%b exp=100", {dl_done, dl_error, core_reset}); end
    endtask
    task automatic test_backpressure();
        clr_mon();
        pop_stall = 1'b1;
        ioctl_download = 1'b1;
        repeat (2) step();
        checks++; if ({core_reset, dl_error} !== 2'b10) begin failures++; $display("FAIL bp_start got=%b exp=10", {core_reset, dl_error}); end
        ioctl_wr = 1'b1; ioctl_addr = 25'd0; ioctl_dout = 8'h5A;
        step();
        ioctl_addr = 25'd1; ioctl_dout = 8'h5B;
        #1;
        checks++; if (ioctl_wait !== 1'b1) begin failures++; $display("FAIL bp_wait2 got=%b exp=1", ioctl_wait); end
        step();
        ioctl_addr = 25'd2; ioctl_dout = 8'h58;
        checks++; if ({ioctl_wait, dl_error} !== 2'b10) begin failures++; $display("FAIL bp_full got=%b exp=10", {ioctl_wait, dl_error}); end
        step();
        ioctl_wr = 1'b0;
        checks++; if ({ioctl_wait, dl_error} !== 2'b11) begin failures++; $display("FAIL bp_drop got=%b exp=11", {ioctl_wait, dl_error}); end
        pop_stall = 1'b0;
        repeat (4) step();
        checks++; if (wr_cnt !== 2 || mon_bad !== 0 || byte_count !== 16'd2 || ioctl_wait !== 1'b0) begin failures++; $display("FAIL bp_drain got=%0d/%0d/%h/%b exp=2/0/0002/0", wr_cnt, mon_bad, byte_count, ioctl_wait); end
    endtask
    task automatic test_out_of_range();
        restart();
        send(25'h0000);
        repeat (3) step();
        checks++; if ({dl_error, byte_count} !== {1'b0, 16'd1}) begin failures++; $display("FAIL oor_base got=%h exp=00001", {dl_error, byte_count}); end
        send(25'h6200);
        repeat (3) step();
        checks++; if (wr_cnt !== 1 || {dl_error, byte_count} !== {1'b1, 16'd1}) begin failures++; $display("FAIL oor_6200 got=%0d/%h exp=1/10001", wr_cnt, {dl_error, byte_count}); end
        restart();
        send(25'h10000);
        repeat (3) step();
        checks++; if (wr_cnt !== 0 || {dl_error, byte_count} !== {1'b1, 16'd0}) begin failures++; $display("FAIL oor_10000 got=%0d/%h exp=0/10000", wr_cnt, {dl_error, byte_count}); end
        next_exp = 16'h0001;
        send(25'h0001);
        repeat (3) step();
        checks++; if (wr_cnt !== 1 || byte_count !== 16'd1 || ioctl_wait !== 1'b0) begin failures++; $display("FAIL oor_consumed got=%0d/%h/%b exp=1/0001/0", wr_cnt, byte_count, ioctl_wait); end
    endtask
    task automatic test_reset_mid_load();
        int snap;
        restart();
        for (int i = 0; i < 100; i++) send(25'(i));
        checks++; if (byte_count !== 16'd99) begin failures++; $display("FAIL rml_pre got=%0d exp=99", byte_count); end
        snap = wr_cnt;
        ioctl_wr = 1'b1; ioctl_addr = 25'd100; ioctl_dout = 8'd100 ^ 8'h5A;
        #2 reset = 1'b1;
        #1;
        checks++; if ({ioctl_wait, dn_wr, dn_addr, dn_data, dn_sel, core_reset, dl_done, dl_error, byte_count} !== RST_VEC) begin failures++; $display("FAIL rml_vec got=%h exp=%h", {ioctl_wait, dn_wr, dn_addr, dn_data, dn_sel, core_reset, dl_done, dl_error, byte_count}, RST_VEC); end
        repeat (2) step();
        reset = 1'b0;
        for (int i = 101; i < 121; i++) send(25'(i));
        repeat (3) step();
        checks++; if (wr_cnt !== snap || {core_reset, dl_error, byte_count} !== {2'b10, 16'd0}) begin failures++; $display("FAIL rml_ignore got=%0d/%h exp=%0d/%h", wr_cnt, {core_reset, dl_error, byte_count}, snap, {2'b10, 16'd0}); end
    endtask
    task automatic test_redownload_hold();
        restart();
        for (int i = 0; i < 4; i++) send(25'(i));
        ioctl_download = 1'b0;
        repeat (20) step();
        checks++; if ({core_reset, dl_error, byte_count} !== {2'b11, 16'd4}) begin failures++; $display("FAIL rdh_hold got=%h exp=%h", {core_reset, dl_error, byte_count}, {2'b11, 16'd4}); end
        ioctl_download = 1'b1;
        step();
        checks++; if ({dl_error, byte_count} !== 17'h0) begin failures++; $display("FAIL rdh_clear got=%h exp=0", {dl_error, byte_count}); end
        next_exp = 16'h0005;
        send(25'h0005);
        repeat (2) step();
        checks++; if (byte_count !== 16'd1 || cr_low !== 0) begin failures++; $display("FAIL rdh_load got=%h/%0d exp=0001/0", byte_count, cr_low); end
        ioctl_download = 1'b0;
        repeat (2) step();
    endtask
    initial begin
        reset = 1'b1; ioctl_download = 1'b0; ioctl_wr = 1'b0; pop_stall = 1'b0;
        ioctl_addr = '0; ioctl_dout = '0;
        clr_mon();
        test_reset();
        test_latency();
        test_short_load();
        test_full_load();
        test_backpressure();
        test_out_of_range();
        test_reset_mid_load();
        test_redownload_hold();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
